// File: rtl/sram_sp_pkg.sv
// sram_sp_pkg: shared state type and default sizing for the single-port
// SRAM request front-end (64x8 macro, registered Q).
package sram_sp_pkg;

    localparam int DEFAULT_BITS       = 8;
    localparam int DEFAULT_ADD_WIDTH  = 6;
    localparam int DEFAULT_WORD_DEPTH = 64;
    localparam int DEFAULT_RESP_DEPTH = 2;

    // INIT is only reachable when the power-up clear sweep is built in.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// sram_resp_fifo: small synchronous FIFO holding read data captured from the
// macro until the consumer takes it. Pointers and count are cleared by reset;
// the storage array is not. Output reads zero while the FIFO is empty.
module sram_resp_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state for storage, pointers and occupancy; push+pop keeps count.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (avoids inferred latches).
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage register array.
    always_ff @(posedge clock) begin
        // NOTE: storage is deliberately not reset; the count guards it, and resetting wide arrays costs routing for nothing.
        mem_q <= mem_d;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/sram_sp_req_ctrl.sv
// sram_sp_req_ctrl: valid/ready request front-end for a single-port SRAM
// macro with active-low CEB/WEB and registered Q. Reads are credited against
// the response FIFO so Q is always captured in its one valid cycle.
// Optional build macro SRAM_INIT_EN: after reset, sweep zeros into every word
// (one per cycle) before accepting requests.
module sram_sp_req_ctrl
    import sram_sp_pkg::*;
#(
    parameter int BITS       = DEFAULT_BITS,
    parameter int WORD_DEPTH = DEFAULT_WORD_DEPTH,
    parameter int ADD_WIDTH  = DEFAULT_ADD_WIDTH,
    parameter int RESP_DEPTH = DEFAULT_RESP_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wen,
    input  logic [ADD_WIDTH-1:0] req_addr,
    input  logic [BITS-1:0]      req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [BITS-1:0]      resp_rdata,
    output logic                 sram_ceb,
    output logic                 sram_web,
    output logic [ADD_WIDTH-1:0] sram_a,
    output logic [BITS-1:0]      sram_d,
    input  logic [BITS-1:0]      sram_q
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    if (WORD_DEPTH != (1 << ADD_WIDTH)) begin : g_bad_depth
        $error("sram_sp_req_ctrl: WORD_DEPTH must equal 2**ADD_WIDTH");
    end
    if (RESP_DEPTH < 2) begin : g_bad_resp_depth
        $error("sram_sp_req_ctrl: RESP_DEPTH must be at least 2");
    end

    logic             run_ok;
    logic             credit_ok;
    logic             accept;
    logic             rd_accept;
    logic             pop;
    logic             inflight_q, inflight_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

`ifdef SRAM_INIT_EN
    state_e               state_q, state_d;
    logic [ADD_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                 init_active;
`endif

    // Acceptance, credit check and macro pin drive; reset forces the pins idle.
    always_comb begin
        // Outstanding reads (buffered + in flight) never exceed the buffer size.
        credit_ok = (int'(fifo_count) + int'(inflight_q)) < RESP_DEPTH;
`ifdef SRAM_INIT_EN
        run_ok      = !reset && (state_q == RUN);
        init_active = !reset && (state_q == INIT);
`else
        run_ok      = !reset;
`endif
        req_ready = run_ok && (req_wen || credit_ok);
        accept    = req_valid && req_ready;
        rd_accept = accept && !req_wen;

        sram_ceb = 1'b1;
        sram_web = 1'b1;
        sram_a   = req_addr;
        sram_d   = req_wdata;
        if (run_ok) begin
            sram_ceb = !accept;
            sram_web = !req_wen;
        end
`ifdef SRAM_INIT_EN
        else if (init_active) begin
            sram_ceb = 1'b0;
            sram_web = 1'b0;
            sram_a   = init_cnt_q;
            sram_d   = '0;
        end
`endif
    end

`ifdef SRAM_INIT_EN
    // Clear-sweep sequencing: one word per cycle, then hand over to RUN.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == INIT) begin
            if (init_cnt_q == ADD_WIDTH'(WORD_DEPTH - 1)) begin
                state_d    = RUN;
                init_cnt_d = '0;
            end else begin
                init_cnt_d = init_cnt_q + ADD_WIDTH'(1);
            end
        end
    end

    // State and sweep counter registers; reset restarts the sweep at word 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end
`endif

    // In-flight flag marks the single cycle in which Q holds read data.
    always_comb begin
        inflight_d = rd_accept;
    end

    // In-flight register; reset drops any read still in the macro pipeline.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign pop        = !fifo_empty && resp_ready;
    assign resp_valid = !fifo_empty;

    sram_resp_fifo #(
        .WIDTH (BITS),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clock (clock),
        .reset (reset),
        .push  (inflight_q),
        .wdata (sram_q),
        .pop   (pop),
        .rdata (resp_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifndef SYNTHESIS
    // Credit accounting must make overflow and underflow impossible.
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(inflight_q && fifo_full))
                else $error("sram_sp_req_ctrl: response buffer push while full");
            assert (!(pop && fifo_empty))
                else $error("sram_sp_req_ctrl: response buffer pop while empty");
        end
    end
`endif

endmodule

// File: tb/tb_sram_sp_req_ctrl.sv
// tb_sram_sp_req_ctrl: directed and random stimulus against a transaction
// model (expected-response queue plus word array). Build with SRAM_INIT_EN to
// also exercise the clear sweep.
module tb_sram_sp_req_ctrl;

    localparam int WD = 64;
    localparam int RD = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_wen;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_rdata;
    logic       sram_ceb;
    logic       sram_web;
    logic [5:0] sram_a;
    logic [7:0] sram_d;
    logic [7:0] sram_q;

    always #5 clock = ~clock;

    sram_sp_req_ctrl #(
        .BITS       (8),
        .WORD_DEPTH (WD),
        .ADD_WIDTH  (6),
        .RESP_DEPTH (RD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .sram_ceb   (sram_ceb),
        .sram_web   (sram_web),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_q     (sram_q)
    );

    // Macro stand-in: registered Q on reads, garbage on every other cycle.
    logic [7:0] mac [WD];
    always @(posedge clock) begin
        if (!sram_ceb && !sram_web) mac[sram_a] <= sram_d;
        if (!sram_ceb && sram_web) sram_q <= mac[sram_a];
        else                       sram_q <= 8'($urandom);
    end

    // Transaction-level reference model.
    typedef struct {
        logic [7:0] data;
        int         avail;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [WD];
    int         edges     = 0;
    int         init_left = 0;
    int         n_cmp     = 0;
    int         n_err     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs mid-cycle, advance model at the edge.
    task automatic step(input logic rst, input logic v, input logic w,
                        input logic [5:0] a, input logic [7:0] d, input logic rr,
                        output logic acc);
        logic exp_rdy, exp_rv, busy, pop;
        reset      = rst;
        req_valid  = v;
        req_wen    = w;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = rr;
        #2;
        busy    = (init_left > 0);
        exp_rdy = !rst && !busy && (w || (exp_q.size() < RD));
        exp_rv  = (exp_q.size() > 0) && (exp_q[0].avail <= edges);
        acc     = v && exp_rdy;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (rst) begin
            chk("rst_ceb", 32'(sram_ceb), 32'(1));
            chk("rst_web", 32'(sram_web), 32'(1));
        end else if (busy) begin
            chk("init_ceb", 32'(sram_ceb), 32'(0));
            chk("init_web", 32'(sram_web), 32'(0));
            chk("init_a", 32'(sram_a), 32'(WD - init_left));
            chk("init_d", 32'(sram_d), 32'(0));
        end else begin
            chk("ceb", 32'(sram_ceb), 32'(!acc));
            chk("web", 32'(sram_web), 32'(!w));
            if (acc) begin
                chk("sram_a", 32'(sram_a), 32'(a));
                chk("sram_d", 32'(sram_d), 32'(d));
            end
        end
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_rv) chk("resp_rdata", 32'(resp_rdata), 32'(exp_q[0].data));
        pop = exp_rv && rr;
        @(posedge clock);
        if (rst) begin
            exp_q.delete();
`ifdef SRAM_INIT_EN
            init_left = WD;
`endif
        end else begin
            if (busy) begin
                ref_mem[WD - init_left] = 8'h00;
                init_left--;
            end
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                if (w) ref_mem[a] = d;
                else   exp_q.push_back('{data: ref_mem[a], avail: edges + 2});
            end
        end
        edges++;
        #1;
    endtask

    // Hold a request until the model says it is accepted (bounded).
    task automatic send(input logic w, input logic [5:0] a, input logic [7:0] d, input logic rr);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) step(1'b0, 1'b1, w, a, d, rr, acc);
    endtask

    task automatic idle(input logic rr);
        logic acc;
        step(1'b0, 1'b0, 1'b0, 6'd0, 8'd0, rr, acc);
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) idle(1'b1);
    endtask

    task automatic wait_init();
        for (int t = 0; t < 200 && init_left > 0; t++) idle(1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Reset held with a live write request: ready low, pins idle.
        step(1'b1, 1'b1, 1'b1, 6'd9, 8'h3C, 1'b1, acc);
        step(1'b1, 1'b1, 1'b0, 6'd9, 8'h3C, 1'b1, acc);

`ifdef SRAM_INIT_EN
        // Sweep partway, reset at address 20, then a full 64-cycle sweep.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'($urandom), 6'($urandom), 8'($urandom), 1'b1, acc);
        step(1'b1, 1'b0, 1'b0, 6'd0, 8'd0, 1'b1, acc);
        wait_init();
        send(1'b0, 6'd0, 8'd0, 1'b1);
        send(1'b0, 6'd63, 8'd0, 1'b1);
        drain();
`endif
        chk("rdata_idle_zero", 32'(resp_rdata), 32'(0));

        // Give every word a known value.
        for (int i = 0; i < WD; i++) send(1'b1, 6'(i), 8'($urandom), 1'b1);

        // Write then read back-to-back at the same address.
        send(1'b1, 6'd3, 8'hA5, 1'b1);
        send(1'b0, 6'd3, 8'h00, 1'b1);
        drain();

        // Backpressure: two reads fill the credits, the third stalls.
        send(1'b0, 6'd1, 8'h00, 1'b0);
        send(1'b0, 6'd2, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 6'd3, 8'h00, 1'b0, acc);
        step(1'b0, 1'b1, 1'b0, 6'd3, 8'h00, 1'b0, acc);
        send(1'b0, 6'd3, 8'h00, 1'b1);
        drain();

        // Streaming reads over the whole array.
        for (int i = 0; i < WD; i++) send(1'b0, 6'(i), 8'h00, 1'b1);
        drain();

        // Writes while the buffer is full are still accepted.
        send(1'b0, 6'd10, 8'h00, 1'b0);
        send(1'b0, 6'd11, 8'h00, 1'b0);
        idle(1'b0);
        send(1'b1, 6'd10, 8'h5A, 1'b0);
        send(1'b1, 6'd11, 8'hC3, 1'b0);
        send(1'b0, 6'd10, 8'h00, 1'b1);
        send(1'b0, 6'd11, 8'h00, 1'b1);
        drain();

        // Reset with one read buffered and one in flight.
        send(1'b0, 6'd7, 8'h00, 1'b0);
        send(1'b0, 6'd8, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0, acc);
        chk("post_rst_rdata", 32'(resp_rdata), 32'(0));
        idle(1'b1);
        wait_init();
        send(1'b1, 6'd5, 8'h77, 1'b1);
        send(1'b0, 6'd5, 8'h00, 1'b1);
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 6'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0), acc);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
